spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI mode-0 slave (responder) byte interface. It is the far end of the SPI master used by the autotest
//  harness (cs/sclk/mosi in, miso out). Used to emulate an SD-card-side peer on the FPGA fabric for loopback
//  and self-test of the benchmark flow. Oversamples the SPI pins in the system clock domain, deserialises
//  MOSI into bytes, and serialises a double-buffered TX byte onto MISO. Sends IDLE_BYTE when no TX data is queued.
// PARAMETERS
//  SYNC_STAGES  2      flip-flop stages on cs/sclk/mosi before edge detection (>=2)
//  IDLE_BYTE    8'hFF  byte shifted out when the TX holding register is empty
// PORTS
//  clk       in   1  system clock; must run >= 2*(SYNC_STAGES+2) x f_sclk
//  rst       in   1  synchronous, active-high reset
//  cs        in   1  SPI chip select from master, active low (asynchronous to clk)
//  sclk      in   1  SPI clock from master, idle low (mode 0)
//  mosi      in   1  SPI data master->slave, MSB first
//  miso      out  1  SPI data slave->master, MSB first; registered
//  rx_data   out  8  last complete received byte; held until the next byte completes
//  rx_valid  out  1  one-cycle pulse when rx_data updates; no backpressure
//  tx_data   in   8  byte to send
//  tx_valid  in   1  write strobe for tx_data; accepted only when tx_ready=1
//  tx_ready  out  1  TX holding register empty
//  busy      out  1  synchronised cs is low (frame active)
//  abort     out  1  one-cycle pulse: cs rose with a partial byte (bit count 1..7)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): miso=1, rx_data=0, rx_valid=0, tx_ready=1, busy=0, abort=0.
//   Bit counter=0. Shift registers=0. Holding register empty. Sync chains preset to cs=1, sclk=0, mosi=1.
//   Reset mid-frame discards all state. The slave is idle until it sees a fresh cs falling edge.
//  Edge detect: compare the last two synchronised samples; one-cycle events cs_fall, cs_rise, sck_rise, sck_fall.
//   All events are ignored while synchronised cs=1, except cs_rise.
//  FSM states:
//   IDLE: miso=1, busy=0.
//    On cs_fall: load tx_shift <= holding (mark holding empty) or IDLE_BYTE if empty.
//    Then miso <= bit7 of the loaded value and go to ACTIVE.
//   ACTIVE: busy=1.
//    sck_rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
//     On the 8th rise (bit_cnt 7->0): rx_data <= completed byte; rx_valid=1 next cycle.
//     Same cycle: tx_shift reloads from holding/IDLE_BYTE (holding marked empty).
//    sck_fall: miso <= next tx bit (tx_shift shifted left).
//     If bit_cnt==0 (byte boundary), miso <= bit7 of the freshly loaded byte instead.
//    cs_rise: -> IDLE, miso=1, bit_cnt=0.
//     If bit_cnt!=0: pulse abort, discard the partial rx byte, no rx_valid.
//     tx_shift is discarded; the holding register is kept.
//  TX handshake: tx_ready = holding empty. tx_valid && tx_ready loads holding; tx_ready drops next cycle.
//   tx_valid with tx_ready=0 is ignored; holding is not overwritten.
//   Simultaneous accept and reload in the same cycle: the reload takes the pre-cycle holding content.
//    If holding was empty, IDLE_BYTE is sent and the new byte stays queued for the following byte.
//  Latency: miso changes SYNC_STAGES+1 clk cycles after the physical sclk fall.
//   rx_valid asserts SYNC_STAGES+2 cycles after the 8th physical sclk rise.
//  cs_rise and sck_rise in the same cycle: cs_rise wins; the edge is not sampled.
// TESTING
//  T1 reset: assert rst 2 cycles with pins toggling -> miso=1, tx_ready=1, busy=0, rx_valid=0, abort=0.
//  T2 single byte: preload tx 8'h3C, master sends 8'hA5 at clk/8.
//   -> exactly one rx_valid, rx_data=8'hA5, master captures 8'h3C, tx_ready=1 after cs_fall.
//  T3 idle fill: no tx write, master sends 8'h00 -> master captures 8'hFF, rx_data=8'h00.
//  T4 stream: master sends 8'h01,8'h02,8'h03 in one cs frame. Bench writes 8'h10,8'h20,8'h30, each on tx_ready.
//   -> rx_valid x3 with 01/02/03, master captures 10/20/30.
//  T5 abort: cs rises after 5 sclk bits -> abort pulse, no rx_valid.
//   Next frame sending 8'h5A -> rx_data=8'h5A.
//  T6 overwrite guard: holding full with 8'hAA, tx_valid with 8'h55 -> ignored, master captures 8'hAA.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave byte interface. The cs/sclk/mosi pins are oversampled in the
// clk domain, MOSI is deserialised into bytes, and a double-buffered TX byte is
// serialised onto MISO. IDLE_BYTE is sent whenever no TX byte is queued.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame; miso parked high, waiting for a cs falling edge
// ACTIVE | frame open; shifting on synchronised sclk edges
module spi_slave_if #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       abort
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_s, sck_s, mosi_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       miso_q, miso_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       abort_q, abort_d;
  logic       tx_load;
  logic [7:0] tx_next;

  // Shift the raw pins into the synchroniser chains and derive one-cycle edge events.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_prev_d   = cs_s;
    sck_prev_d  = sck_s;
    cs_fall     = cs_prev_q & ~cs_s;
    cs_rise     = ~cs_prev_q & cs_s;
    // sclk edges only count inside a frame
    sck_rise    = ~cs_s & ~sck_prev_q & sck_s;
    sck_fall    = ~cs_s & sck_prev_q & ~sck_s;
  end

  // Frame FSM, shift registers and TX holding-register handshake.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    rx_done_d   = 1'b0;
    abort_d     = 1'b0;
    tx_load     = 1'b0;
    // Reload always uses the pre-cycle holding content
    tx_next     = hold_full_q ? hold_q : IDLE_BYTE;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b1;
        if (cs_fall) begin
          tx_load    = 1'b1;
          miso_d     = tx_next[7];
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          state_d    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          // cs_rise wins over a coincident sclk edge
          state_d    = S_IDLE;
          miso_d     = 1'b1;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          tx_shift_d = 8'h00;
          abort_d    = (bit_cnt_q != 3'd0);
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = {rx_shift_q[6:0], mosi_s};
            rx_done_d = 1'b1;
            tx_load   = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            // Byte boundary: present the MSB of the freshly loaded byte
            miso_d = tx_shift_q[7];
          end else begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d  = tx_next;
      hold_full_d = 1'b0;
    end
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    rx_valid_d = rx_done_q;
  end

  // Register update with synchronous reset; chains preset to the idle pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '1;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b1;
      rx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      rx_done_q   <= rx_done_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;
  assign busy     = (state_q == S_ACTIVE);
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: table of single-byte frames plus hand-written
// stream, abort and overwrite-guard sequences, with scoreboard queues for
// received bytes and bytes captured by the bench-side SPI master.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs, sclk, mosi, miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_valid, tx_ready, busy, abort;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  typedef struct {
    logic [7:0] mosi_b;
    logic       pre;
    logic [7:0] tx_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  spi_slave_if #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .abort(abort)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pops one expected byte
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_cnt++;
      if (exp_rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: actual=%0h required=none", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
    if (!rst && abort) abort_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = mo[i];
      wait_clk(4);
      sclk = 1'b1;
      mi[i] = miso;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] mo);
    logic [7:0] got;
    spi_bits(mo, 8, got);
    if (exp_miso_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL miso_byte: actual=%0h required=none", got);
    end else begin
      chk("miso_byte", got, exp_miso_q.pop_front());
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs = 1'b1;
    wait_clk(12);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 500) begin
      wait_clk(1);
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      $display("FAIL tx_ready_timeout: actual=0 required=1");
    end
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, ab0;
    logic [7:0] junk;

    vecs[0] = '{mosi_b: 8'hA5, pre: 1'b1, tx_b: 8'h3C, exp_rx: 8'hA5, exp_miso: 8'h3C};
    vecs[1] = '{mosi_b: 8'h00, pre: 1'b0, tx_b: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[2] = '{mosi_b: 8'hFF, pre: 1'b1, tx_b: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[3] = '{mosi_b: 8'h81, pre: 1'b1, tx_b: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};
    vecs[4] = '{mosi_b: 8'h69, pre: 1'b0, tx_b: 8'h00, exp_rx: 8'h69, exp_miso: 8'hFF};

    // T1: reset with pins toggling
    rst = 1'b1; cs = 1'b0; sclk = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cs = ~cs; sclk = ~sclk; mosi = 1'($urandom_range(0, 1));
    end
    wait_clk(1);
    chk("rst_miso", miso, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_abort", abort, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
    rst = 1'b0;
    wait_clk(6);
    chk("idle_busy", busy, 0);

    // T2/T3 and more: single-byte frames from the table
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].pre) begin
        tx_write(vecs[k].tx_b);
        chk("tx_ready_full", tx_ready, 0);
      end
      rx0 = rx_cnt;
      exp_rx_q.push_back(vecs[k].exp_rx);
      exp_miso_q.push_back(vecs[k].exp_miso);
      cs_low();
      chk("tx_ready_after_csfall", tx_ready, 1);
      chk("busy_in_frame", busy, 1);
      xfer_byte(vecs[k].mosi_b);
      cs_high();
      chk("rx_count_single", rx_cnt - rx0, 1);
      chk("busy_after_frame", busy, 0);
    end

    // T4: three-byte stream, TX refilled on each tx_ready
    rx0 = rx_cnt;
    exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h02); exp_rx_q.push_back(8'h03);
    exp_miso_q.push_back(8'h10); exp_miso_q.push_back(8'h20); exp_miso_q.push_back(8'h30);
    tx_write(8'h10);
    cs_low();
    fork
      begin
        tx_write(8'h20);
        tx_write(8'h30);
      end
      begin
        xfer_byte(8'h01);
        xfer_byte(8'h02);
        xfer_byte(8'h03);
      end
    join
    cs_high();
    chk("rx_count_stream", rx_cnt - rx0, 3);
    chk("tx_ready_stream_end", tx_ready, 1);

    // T5: abort after 5 bits, then a clean frame
    rx0 = rx_cnt;
    ab0 = abort_cnt;
    cs_low();
    spi_bits(8'hB6, 5, junk);
    cs_high();
    chk("abort_count", abort_cnt - ab0, 1);
    chk("abort_no_rx", rx_cnt - rx0, 0);
    chk("abort_busy", busy, 0);
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(8'hFF);
    cs_low();
    xfer_byte(8'h5A);
    cs_high();
    chk("after_abort_rx_count", rx_cnt - rx0, 1);
    chk("after_abort_no_abort", abort_cnt - ab0, 1);

    // T6: write while holding is full is ignored
    tx_write(8'hAA);
    chk("guard_ready_full", tx_ready, 0);
    tx_data = 8'h55; tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    chk("guard_ready_still_full", tx_ready, 0);
    exp_rx_q.push_back(8'hC3);
    exp_miso_q.push_back(8'hAA);
    cs_low();
    xfer_byte(8'hC3);
    cs_high();
    exp_rx_q.push_back(8'h3C);
    exp_miso_q.push_back(8'hFF);
    cs_low();
    xfer_byte(8'h3C);
    cs_high();

    wait_clk(4);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    chk("miso_queue_drained", exp_miso_q.size(), 0);
    chk("abort_total", abort_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
